// File: rtl/ext_irq_ctrl_pkg.sv
// Purpose: shared types and constants for the external interrupt requester.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package ext_irq_pkg;

    // Request handshake phases seen from the requester side.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_REL = 2'd2
    } irq_state_t;

    // Mask register sits on the last doubleword of data memory.
    localparam logic [63:0] DEF_MASK_ADDR = 64'h7F8;

    // Width of a source index; never narrower than one bit.
    function automatic int id_width(input int nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

endpackage

// File: rtl/ext_irq_ctrl_prio_enc.sv
// Purpose: fixed-priority encoder, lowest set index wins.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the request vector.
// Ports: req (W-bit request vector) -> any_vld (any bit set), idx (winning index, 0 when none).
module irq_prio_enc
    import ext_irq_pkg::*;
#(
    parameter int W   = 4,
    parameter int IDW = id_width(W)
) (
    input  logic [W-1:0]   req,
    output logic           any_vld,
    output logic [IDW-1:0] idx
);

    // Scan from the top down so the last hit, i.e. the lowest index, sticks.
    always_comb begin
        any_vld = |req;
        idx     = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/ext_irq_ctrl.sv
// Purpose: external interrupt requester driving ExtIRQ/ExtIAck with edge-latched, maskable sources.
// Latency: rising source pends at edge t, ExtIRQ high after t+1; ack at edge a drops ExtIRQ and clears the bit after a.
// Backpressure: a request is held until ExtIAck; a new request waits for ExtIAck to fall (one service per ack).
// Ports: CLOCK_50/reset (async active-low); irq_src source levels; DM_addr/DM_writeData/DM_writeEnable
//        snooped store bus for the mask register; ExtIAck from the core; ExtIRQ, irq_id, pending, mask out.
module ext_irq_ctrl
    import ext_irq_pkg::*;
#(
    parameter int              N         = 64,
    parameter int              NSRC      = 4,
    parameter logic [N-1:0]    MASK_ADDR = N'(DEF_MASK_ADDR),
    localparam int             IDW       = id_width(NSRC)
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [NSRC-1:0]    irq_src,
    input  logic [N-1:0]       DM_addr,
    input  logic [N-1:0]       DM_writeData,
    input  logic               DM_writeEnable,
    input  logic               ExtIAck,
    output logic               ExtIRQ,
    output logic [IDW-1:0]     irq_id,
    output logic [NSRC-1:0]    pending,
    output logic [NSRC-1:0]    mask
);

    irq_state_t      state;
    logic [NSRC-1:0] src_prev;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] eligible;
    logic            sel_vld;
    logic [IDW-1:0]  sel_idx;
    logic            mask_wr;

    // Only the low NSRC bits of a mask store carry meaning.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, DM_writeData[N-1:NSRC]};

    assign rise     = irq_src & ~src_prev;
    assign eligible = pending & mask;
    assign mask_wr  = DM_writeEnable && (DM_addr == MASK_ADDR);

    // The source being serviced retires in the cycle its ack is sampled.
    assign clr = (state == REQ && ExtIAck) ? (NSRC'(1) << irq_id) : '0;

    irq_prio_enc #(
        .W   (NSRC),
        .IDW (IDW)
    ) u_prio_enc (
        .req     (eligible),
        .any_vld (sel_vld),
        .idx     (sel_idx)
    );

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ExtIRQ   <= 1'b0;
            irq_id   <= '0;
            pending  <= '0;
            mask     <= '1;
            src_prev <= '0;
        end else begin
            src_prev <= irq_src;
            // A fresh edge beats a same-cycle clear so no event is lost.
            pending  <= rise | (pending & ~clr);
            if (mask_wr) begin
                mask <= DM_writeData[NSRC-1:0];
            end

            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        irq_id <= sel_idx;
                        ExtIRQ <= 1'b1;
                        state  <= REQ;
                    end
                end
                // irq_id and ExtIRQ are frozen here regardless of mask or new pends.
                REQ: begin
                    if (ExtIAck) begin
                        ExtIRQ <= 1'b0;
                        state  <= WAIT_REL;
                    end
                end
                // A long ack must not retire a second source.
                WAIT_REL: begin
                    if (!ExtIAck) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    ExtIRQ <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
